// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage holds req and addr steady until ready completes the request.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from variable-latency imem,
// buffers words in an output register plus a one-entry skid, and applies redirects.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clock,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [15:0]       branch_off,
    input  logic              jump_en,
    input  logic [25:0]       jump_idx,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic              consume;
    logic              redirect;
    logic              accept;

    assign step     = ADDR_W'(PC_STEP);
    assign consume  = out_valid_q & ~stall;
    assign redirect = out_valid_q & (jr_en | jump_en | branch_en);

    // A full skid is the only thing that withdraws the request; stall never does.
    assign imem.imem_req  = ~skid_valid_q;
    assign imem.imem_addr = pc_q;
    assign accept         = imem.imem_req & imem.imem_ready;

    assign instr_valid = out_valid_q;
    assign instr       = out_data_q;
    assign instr_pc    = out_pc_q;
    assign pc          = pc_q;

    // Redirect target for the instruction in OUT, priority jr > jump > branch.
    always_comb begin
        seq_pc          = out_pc_q + step;
        redirect_target = seq_pc + ({{(ADDR_W-16){branch_off[15]}}, branch_off} << 2);
        if (jump_en) begin
            redirect_target       = seq_pc;
            redirect_target[27:0] = {jump_idx, 2'b00};
        end
        if (jr_en) begin
            redirect_target = jr_addr;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                    // An outstanding request must finish on its old address before the PC moves.
                    if (imem.imem_req && !imem.imem_ready) begin
                        target_d = redirect_target;
                        state_d  = DRAIN;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else begin
                    if (consume) begin
                        if (skid_valid_q) begin
                            out_data_d   = skid_data_q;
                            out_pc_d     = skid_pc_q;
                            skid_valid_d = 1'b0;
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end
                    if (accept) begin
                        pc_d = pc_q + step;
                        if ((!out_valid_q || consume) && !skid_valid_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = imem.imem_rdata;
                            out_pc_d    = pc_q;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = imem.imem_rdata;
                            skid_pc_d    = pc_q;
                        end
                    end
                end
            end
            DRAIN: begin
                if (imem.imem_ready) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            target_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-stream model (program order with redirects).
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_off = '0;
    logic        jump_en = 1'b0;
    logic [25:0] jump_idx = '0;
    logic        jr_en = 1'b0;
    logic [31:0] jr_addr = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clock(clock), .reset(reset), .imem(bus.master), .stall(stall),
        .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
        .jump_idx(jump_idx), .jr_en(jr_en), .jr_addr(jr_addr),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc(pc)
    );

    always #5 clock = ~clock;

    // Contents of instruction memory: a fixed, address-unique pattern.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] ipc, input logic [15:0] off,
                                               input logic [25:0] idx, input logic [31:0] jra,
                                               input logic jr, input logic jmp);
        logic [31:0] seq;
        int          o;
        seq = ipc + 32'd4;
        o   = int'($signed(off));
        if (jr) return jra;
        if (jmp) return {seq[31:28], idx, 2'b00};
        return seq + 32'(o * 4);
    endfunction

    task automatic tick(input logic rdy, input logic stl);
        bus.imem_ready = rdy;
        stall          = stl;
        bus.imem_rdata = word(bus.imem_addr);
        @(posedge clock);
        #1;
        branch_en = 1'b0;
        jump_en   = 1'b0;
        jr_en     = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_req got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got %h want 0", bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_out got %h/%h want 0/0", instr, instr_pc); end
        // Reset while draining a redirect abandons it.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        jump_en = 1'b1; jump_idx = 26'h40;
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_abandon got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_abandon_state got valid=%b pc=%h want 0/0", instr_valid, pc); end
    endtask

    task automatic test_sequential;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0);
            checks++; if (bus.imem_addr !== 32'(4*k) || pc !== 32'(4*k)) begin errors++; $display("[TB] FAIL seq_addr got %h want %h", bus.imem_addr, 32'(4*k)); end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4*(k-1)) || instr !== word(32'(4*(k-1)))) begin
                errors++; $display("[TB] FAIL seq_out got v=%b pc=%h w=%h want pc=%h", instr_valid, instr_pc, instr, 32'(4*(k-1))); end
        end
    endtask

    task automatic test_ready_hold;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL hold got req=%b addr=%h v=%b want 1/8/0", bus.imem_req, bus.imem_addr, instr_valid); end
        end
        tick(1'b1, 1'b0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== word(32'h8) || pc !== 32'hC) begin
            errors++; $display("[TB] FAIL hold_deliver got v=%b ipc=%h pc=%h want 1/8/c", instr_valid, instr_pc, pc); end
        tick(1'b0, 1'b0);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_nodup got %b want 0", instr_valid); end
    endtask

    task automatic test_stall_skid;
        do_reset();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || bus.imem_req !== 1'b0 || pc !== 32'h8) begin
                errors++; $display("[TB] FAIL stall got v=%b ipc=%h req=%b pc=%h want 1/0/0/8", instr_valid, instr_pc, bus.imem_req, pc); end
        end
        for (int j = 1; j <= 4; j++) begin
            tick(1'b1, 1'b0);
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4*j) || instr !== word(32'(4*j))) begin
                errors++; $display("[TB] FAIL release got v=%b ipc=%h want 1/%h", instr_valid, instr_pc, 32'(4*j)); end
        end
    endtask

    task automatic test_branch;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        checks++; if (instr_pc !== 32'h10) begin errors++; $display("[TB] FAIL br_setup got %h want 10", instr_pc); end
        branch_en = 1'b1; branch_off = 16'hFFFE;
        tick(1'b1, 1'b0);
        checks++; if (instr_valid !== 1'b0 || bus.imem_addr !== 32'hC) begin
            errors++; $display("[TB] FAIL br_redirect got v=%b addr=%h want 0/c", instr_valid, bus.imem_addr); end
        tick(1'b1, 1'b0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== word(32'hC)) begin
            errors++; $display("[TB] FAIL br_target got v=%b ipc=%h want 1/c", instr_valid, instr_pc); end
    endtask

    task automatic test_priority;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        jr_en = 1'b1; jump_en = 1'b1; branch_en = 1'b1;
        jr_addr = 32'h400; jump_idx = 26'h123; branch_off = 16'h5;
        tick(1'b1, 1'b1);
        checks++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
            errors++; $display("[TB] FAIL prio got v=%b req=%b addr=%h want 0/1/400", instr_valid, bus.imem_req, bus.imem_addr); end
        tick(1'b1, 1'b0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400 || instr !== word(32'h400)) begin
            errors++; $display("[TB] FAIL prio_fetch got v=%b ipc=%h want 1/400", instr_valid, instr_pc); end
    endtask

    task automatic test_drain;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        jump_en = 1'b1; jump_idx = 26'h40;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
                errors++; $display("[TB] FAIL drain_hold got v=%b req=%b addr=%h want 0/1/c", instr_valid, bus.imem_req, bus.imem_addr); end
            tick(i == 1, 1'b0);
        end
        checks++; if (instr_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL drain_drop got v=%b addr=%h want 0/100", instr_valid, bus.imem_addr); end
        tick(1'b1, 1'b0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== word(32'h100)) begin
            errors++; $display("[TB] FAIL drain_target got v=%b ipc=%h want 1/100", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap;
        do_reset();
        tick(1'b1, 1'b0);
        jr_en = 1'b1; jr_addr = 32'hFFFF_FFFC;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++; if (instr_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL wrap got ipc=%h addr=%h want fffffffc/0", instr_pc, bus.imem_addr); end
        tick(1'b1, 1'b0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("[TB] FAIL wrap_next got v=%b ipc=%h want 1/0", instr_valid, instr_pc); end
    endtask

    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_hold;
        logic        rdy, stl;
        int          idle;
        do_reset();
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        prev_addr = '0;
        idle      = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (prev_hold) begin
                checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                    errors++; $display("[TB] FAIL rnd_hold got req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, prev_addr); end
            end
            if (instr_valid === 1'b1) begin
                idle = 0;
                checks++; if (instr_pc !== exp_pc || instr !== word(exp_pc)) begin
                    errors++; $display("[TB] FAIL rnd_stream got pc=%h w=%h want pc=%h w=%h", instr_pc, instr, exp_pc, word(exp_pc)); end
            end else begin
                idle++;
                if (idle > 64) begin
                    checks++; errors++;
                    $display("[TB] FAIL rnd_liveness got %0d idle cycles want <= 64", idle);
                    break;
                end
            end
            rdy = ($urandom_range(0, 2) != 0);
            stl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                jr_en      = ($urandom_range(0, 2) == 0);
                jump_en    = ($urandom_range(0, 1) == 0);
                branch_en  = 1'b1;
                jr_addr    = $urandom & 32'hFFFF_FFFC;
                jump_idx   = 26'($urandom);
                branch_off = 16'($urandom);
            end
            if (instr_valid === 1'b1) begin
                if (jr_en || jump_en || branch_en)
                    exp_pc = ref_target(exp_pc, branch_off, jump_idx, jr_addr, jr_en, jump_en);
                else if (!stl)
                    exp_pc = exp_pc + 32'd4;
            end
            prev_hold = bus.imem_req && !rdy;
            prev_addr = bus.imem_addr;
            tick(rdy, stl);
        end
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        test_reset();
        test_sequential();
        test_ready_hold();
        test_stall_skid();
        test_branch();
        test_priority();
        test_drain();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
